// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: two-flop synchronizer, four-state stability qualifier,
// and registered debounced level plus one-cycle rise/fall pulses.
module btn_debounce_pulse #(
  parameter int STABLE_CYCLES = 100,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_db,
  output logic btn_rise,
  output logic btn_fall
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_btn_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_btn_db;
  logic             r_btn_rise;
  logic             r_btn_fall;
  logic             w_level_hi;

  // Two-flop synchronizer for the raw asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_btn_s <= r_sync1;
    end
  end

  // Qualifier state and stability counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STABLE_LO;
      r_cnt   <= LP_CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; any reversal during a WAIT state restarts from zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = LP_CNT_ZERO;
    case (r_state)
      STABLE_LO: begin
        if (r_btn_s) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = LP_CNT_ONE;
        end else begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = LP_CNT_ZERO;
        end
      end
      WAIT_HI: begin
        if (!r_btn_s) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = LP_CNT_ZERO;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = LP_CNT_ZERO;
        end else begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = r_cnt + LP_CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!r_btn_s) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = LP_CNT_ONE;
        end else begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = LP_CNT_ZERO;
        end
      end
      WAIT_LO: begin
        if (r_btn_s) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = LP_CNT_ZERO;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = LP_CNT_ZERO;
        end else begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = r_cnt + LP_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = LP_CNT_ZERO;
      end
    endcase
  end

  assign w_level_hi = (r_state == STABLE_HI) || (r_state == WAIT_LO);

  // Registered outputs; a pulse fires on the first cycle the level flips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_db   <= 1'b0;
      r_btn_rise <= 1'b0;
      r_btn_fall <= 1'b0;
    end else begin
      r_btn_db   <= w_level_hi;
      r_btn_rise <= (r_state == STABLE_HI) && !r_btn_db;
      r_btn_fall <= (r_state == STABLE_LO) && r_btn_db;
    end
  end

  assign btn_db   = r_btn_db;
  assign btn_rise = r_btn_rise;
  assign btn_fall = r_btn_fall;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with STABLE_CYCLES=4: edge-exact timing,
// bounce, glitch, reset abort and a downstream press counter.
module tb_btn_debounce_pulse;

  localparam int SC = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn   = 1'b0;
  logic       btn_db;
  logic       btn_rise;
  logic       btn_fall;

  int         errors    = 0;
  int         checks    = 0;
  int         rise_cnt  = 0;
  int         fall_cnt  = 0;
  int         bad_pulse = 0;
  logic       prev_pulse = 1'b0;
  logic       cnt_clr   = 1'b0;
  logic [7:0] press_cnt = 8'd0;
  int         r_base;
  int         f_base;

  always #5 clk = ~clk;

  btn_debounce_pulse #(.STABLE_CYCLES(SC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .btn_db   (btn_db),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (btn_rise === 1'b1) rise_cnt <= rise_cnt + 1;
    if (btn_fall === 1'b1) fall_cnt <= fall_cnt + 1;
    if ((btn_rise === 1'b1) && (btn_fall === 1'b1)) bad_pulse <= bad_pulse + 1;
    if (((btn_rise === 1'b1) || (btn_fall === 1'b1)) && prev_pulse) bad_pulse <= bad_pulse + 1;
    prev_pulse <= (btn_rise === 1'b1) || (btn_fall === 1'b1);
  end

  // Downstream 8-bit press counter driven by btn_rise.
  always @(posedge clk) begin
    if (cnt_clr) press_cnt <= 8'd0;
    else if (btn_rise === 1'b1) press_cnt <= press_cnt + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic bounce_press();
    @(negedge clk);
    btn = 1'b1; #1 btn = 1'b0; #1 btn = 1'b1; #1 btn = 1'b0; #1 btn = 1'b1;
  endtask

  task automatic bounce_release();
    @(negedge clk);
    btn = 1'b0; #1 btn = 1'b1; #1 btn = 1'b0; #1 btn = 1'b1; #1 btn = 1'b0;
  endtask

  initial begin
    // Reset state, independent of clock and input activity.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_db",   {31'd0, btn_db},   32'd0);
    chk("rst_rise", {31'd0, btn_rise}, 32'd0);
    chk("rst_fall", {31'd0, btn_fall}, 32'd0);
    btn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_hold_db",   {31'd0, btn_db},   32'd0);
    chk("rst_hold_rise", 32'(rise_cnt),     32'd0);
    btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Clean press: sampled at edge N, level and pulse after edge N+6.
    @(negedge clk);
    btn = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("press_n5_db",   {31'd0, btn_db},   32'd0);
    chk("press_n5_rise", {31'd0, btn_rise}, 32'd0);
    @(posedge clk); #1;
    chk("press_n6_db",   {31'd0, btn_db},   32'd1);
    chk("press_n6_rise", {31'd0, btn_rise}, 32'd1);
    @(posedge clk); #1;
    chk("press_n7_rise", {31'd0, btn_rise}, 32'd0);
    chk("press_n7_db",   {31'd0, btn_db},   32'd1);
    repeat (200) @(posedge clk); #1;
    chk("hold_no_repeat", 32'(rise_cnt), 32'd1);

    // Clean release.
    @(negedge clk);
    btn = 1'b0;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("rel_n5_db",   {31'd0, btn_db},   32'd1);
    chk("rel_n5_fall", {31'd0, btn_fall}, 32'd0);
    @(posedge clk); #1;
    chk("rel_n6_db",   {31'd0, btn_db},   32'd0);
    chk("rel_n6_fall", {31'd0, btn_fall}, 32'd1);
    @(posedge clk); #1;
    chk("rel_n7_fall", {31'd0, btn_fall}, 32'd0);
    repeat (10) @(posedge clk); #1;
    chk("rel_fall_total", 32'(fall_cnt), 32'd1);

    // Glitch of three clock cycles is rejected.
    r_base = rise_cnt;
    f_base = fall_cnt;
    @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("glitch_db",   {31'd0, btn_db},        32'd0);
    chk("glitch_rise", 32'(rise_cnt - r_base), 32'd0);
    chk("glitch_fall", 32'(fall_cnt - f_base), 32'd0);

    // Bounced press held 5000 ns.
    r_base = rise_cnt;
    f_base = fall_cnt;
    bounce_press();
    #5000;
    @(posedge clk); #1;
    chk("bpress_db",   {31'd0, btn_db},        32'd1);
    chk("bpress_rise", 32'(rise_cnt - r_base), 32'd1);
    chk("bpress_fall", 32'(fall_cnt - f_base), 32'd0);

    // Bounced release held 5000 ns.
    r_base = rise_cnt;
    f_base = fall_cnt;
    bounce_release();
    #5000;
    @(posedge clk); #1;
    chk("brel_db",   {31'd0, btn_db},        32'd0);
    chk("brel_fall", 32'(fall_cnt - f_base), 32'd1);
    chk("brel_rise", 32'(rise_cnt - r_base), 32'd0);

    // Reset while qualifying a press, released with the button still held.
    r_base = rise_cnt;
    f_base = fall_cnt;
    @(negedge clk);
    btn = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstq_in_db",   {31'd0, btn_db},        32'd0);
    chk("rstq_in_rise", 32'(rise_cnt - r_base), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("rstq_n5_rise", {31'd0, btn_rise}, 32'd0);
    @(posedge clk); #1;
    chk("rstq_n6_rise", {31'd0, btn_rise}, 32'd1);
    chk("rstq_n6_db",   {31'd0, btn_db},   32'd1);
    repeat (20) @(posedge clk); #1;
    chk("rstq_rise_total", 32'(rise_cnt - r_base), 32'd1);
    chk("rstq_fall_total", 32'(fall_cnt - f_base), 32'd0);
    @(negedge clk);
    btn = 1'b0;
    repeat (20) @(posedge clk);

    // Integration: three bounced press/release pairs feed the press counter.
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bounce_press();
      repeat (100) @(posedge clk); #1;
      chk("press_counter", {24'd0, press_cnt}, 32'(i));
      bounce_release();
      repeat (100) @(posedge clk);
    end

    #1;
    chk("pulse_overlap_or_consecutive", 32'(bad_pulse), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
